// File: rtl/pressure_array.sv
// Pressure/slider input array: per-channel synchroniser, debouncer, press
// edge detector and wrapping press counter with a sticky overflow flag.
// One channel's count is read back through a registered read port.
module pressure_array #(
  parameter int N_CH       = 3,
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  slider,
  input  logic             clr,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [N_CH-1:0]  LED,
  output logic [N_CH-1:0]  press_pulse,
  output logic [N_CH-1:0]  overflow
);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic [N_CH-1:0]  sync_meta;
  logic [N_CH-1:0]  sync;
  logic [N_CH-1:0]  stable;
  logic [N_CH-1:0]  stable_d;
  logic [DEB_W-1:0] deb_cnt [N_CH];
  logic [CNT_W-1:0] count   [N_CH];

  // Two-flop synchroniser bringing the raw slider inputs into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync      <= '0;
    end else begin
      sync_meta <= slider;
      sync      <= sync_meta;
    end
  end

  // Debouncer: a channel's stable state only follows its synchronised input
  // after the input has disagreed with it for DEB_CYCLES consecutive cycles;
  // any cycle of agreement restarts the hold count, so short glitches vanish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable <= '0;
      for (int i = 0; i < N_CH; i++) begin
        deb_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (sync[i] != stable[i]) begin
          if (deb_cnt[i] == DEB_LAST) begin
            stable[i]  <= sync[i];
            deb_cnt[i] <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + DEB_W'(1);
          end
        end else begin
          deb_cnt[i] <= '0;
        end
      end
    end
  end

  // Press detector: one-cycle strobe in the cycle after stable rises; a
  // release (falling stable) produces nothing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d    <= '0;
      press_pulse <= '0;
    end else begin
      stable_d    <= stable;
      press_pulse <= stable & ~stable_d;
    end
  end

  // Press counters: each strobe bumps its channel's count, wrapping to zero
  // and latching the overflow flag; clr empties every counter and flag and
  // takes priority, so a press landing on the same edge is dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= '0;
      for (int i = 0; i < N_CH; i++) begin
        count[i] <= '0;
      end
    end else if (clr) begin
      overflow <= '0;
      for (int i = 0; i < N_CH; i++) begin
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (press_pulse[i]) begin
          count[i] <= count[i] + CNT_W'(1);
          if (count[i] == {CNT_W{1'b1}}) begin
            overflow[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Read port: registers the pre-edge count of the selected channel; selects
  // beyond the last channel read back as zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt <= '0;
    end else begin
      rd_cnt <= '0;
      for (int i = 0; i < N_CH; i++) begin
        if (rd_sel == SEL_W'(i)) begin
          rd_cnt <= count[i];
        end
      end
    end
  end

  assign LED = ~stable;

endmodule
